viol_rst_ctrl: RTL and testbench
================================

Name: viol_rst_ctrl

Overview:
- Sits directly downstream of the memory-access-control monitor. Consumes its single-bit violation/reset request.
- Turns that request into a clean, fixed-length CPU reset pulse (openMSP430 reset input).
- Records forensic state for software after the CPU restarts: violating PC, data address, code address, sticky flag, saturating violation count.
- Guarantees one reset sequence per violation burst, with a blanking cycle so lingering requests cannot retrigger while the CPU comes out of reset.

Parameters:
- HOLD_CYCLES, 16: number of cycles cpu_rst stays high per accepted violation. Legal range is 1..255.
- CNT_W, 8: width of the saturating violation counter.

Ports:
- clk  input  1  system clock. All logic is on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- violation  input  1  violation/reset request from the access-control monitor. Level-sensitive.
- pc  input  16  current CPU program counter.
- data_addr  input  16  current data-bus address.
- code_addr  input  16  current code-bus address.
- clr_status  input  1  one-cycle pulse that clears the recorded status.
- cpu_rst  output  1  active-high reset to the CPU core.
- busy  output  1  high while the FSM is not in IDLE.
- viol_sticky  output  1  set by any accepted violation. Cleared by clr_status.
- viol_pc  output  16  pc captured at the accepted violation.
- viol_daddr  output  16  data_addr captured at the accepted violation.
- viol_caddr  output  16  code_addr captured at the accepted violation.
- viol_count  output  CNT_W  number of accepted violations, saturating.

Behaviour:
- Single clock. Reset is synchronous and active-low: when reset_n is sampled low at a rising edge, state goes to IDLE and every output and register is cleared.
  - This includes cpu_rst, busy, viol_sticky, viol_pc, viol_daddr, viol_caddr, viol_count and the hold counter.
  - Reset mid-HOLD therefore drops cpu_rst at that same edge.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, HOLD, RELEASE.
- IDLE:
  - violation=1 at edge t means the violation is accepted.
  - At edge t: pc, data_addr and code_addr are captured into viol_pc, viol_daddr and viol_caddr; viol_sticky is set; viol_count increments.
  - The hold counter is loaded with HOLD_CYCLES-1 and the state goes to HOLD.
  - Visible result: cpu_rst=1 and busy=1 in the cycle after edge t.
- HOLD:
  - cpu_rst=1. The counter decrements each edge.
  - At counter==0, the state goes to RELEASE and cpu_rst drops.
  - cpu_rst is high for exactly HOLD_CYCLES cycles: t+1 .. t+HOLD_CYCLES.
  - violation is ignored: no capture, no count.
- RELEASE:
  - Lasts one cycle. cpu_rst=0, busy=1, violation ignored.
  - Always goes to IDLE. The earliest next acceptance is at edge t+HOLD_CYCLES+2.
- viol_count saturates at 2^CNT_W-1 and never wraps.
- clr_status:
  - Clears viol_sticky, viol_count and the three capture registers in any state.
  - It does not affect the FSM or cpu_rst.
  - If clr_status and an accepted violation occur at the same edge, the violation wins: count=1, sticky=1, fresh captures.
- A violation level held high continuously retriggers once per HOLD_CYCLES+2 cycles.

Test Plan:
- Single pulse, HOLD_CYCLES=16: violation high for 1 cycle at edge 10 with pc=A010, data_addr=0600, code_addr=A010 → cpu_rst high on cycles 11..26 and low at 27; busy high on cycles 11..27; viol_pc=A010, viol_daddr=0600, viol_count=1, viol_sticky=1.
- Continuous violation for 40 cycles starting at edge 0 → acceptances at edges 0, 18 and 36; viol_count=3; cpu_rst low on cycles 17 and 35; captures reflect the inputs at edge 36.
- CNT_W=2, five separate violations spaced 20 cycles apart → viol_count sequence 1, 2, 3, 3, 3; viol_sticky stays 1.
- clr_status pulse while in HOLD → count, sticky and captures become 0 next cycle, cpu_rst is unaffected. clr_status coincident with an IDLE violation → count=1, sticky=1.
- reset_n low for one edge at the 5th HOLD cycle → all outputs 0 in the next cycle; state IDLE; a violation at the following edge is accepted normally.
- HOLD_CYCLES=1: violation at edge 0 → cpu_rst high only on cycle 1, RELEASE on cycle 2, next acceptance possible at edge 3.

Source files
------------

// File: rtl/viol_rst_ctrl.sv
// Converts a level violation request into a fixed-length CPU reset pulse and
// records forensic status (captured addresses, sticky flag, saturating count).
module viol_rst_ctrl #(
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             violation,
    input  logic [15:0]      pc,
    input  logic [15:0]      data_addr,
    input  logic [15:0]      code_addr,
    input  logic             clr_status,
    output logic             cpu_rst,
    output logic             busy,
    output logic             viol_sticky,
    output logic [15:0]      viol_pc,
    output logic [15:0]      viol_daddr,
    output logic [15:0]      viol_caddr,
    output logic [CNT_W-1:0] viol_count
);

    localparam int unsigned HOLD_W = 8;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_HOLD    = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_cnt_nxt;
    logic              w_accept;

    logic              r_cpu_rst;
    logic              r_busy;
    logic              r_viol_sticky;
    logic [15:0]       r_viol_pc;
    logic [15:0]       r_viol_daddr;
    logic [15:0]       r_viol_caddr;
    logic [CNT_W-1:0]  r_viol_count;

    // Next-state: requests are only accepted in IDLE; RELEASE is the blanking cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        w_accept       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (violation) begin
                    w_accept       = 1'b1;
                    w_state_nxt    = S_HOLD;
                    w_hold_cnt_nxt = HOLD_LOAD;
                end
            end
            S_HOLD: begin
                if (r_hold_cnt == '0) begin
                    w_state_nxt = S_RELEASE;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt - HOLD_W'(1);
                end
            end
            S_RELEASE: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_hold_cnt    <= '0;
            r_cpu_rst     <= 1'b0;
            r_busy        <= 1'b0;
            r_viol_sticky <= 1'b0;
            r_viol_pc     <= '0;
            r_viol_daddr  <= '0;
            r_viol_caddr  <= '0;
            r_viol_count  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_cpu_rst  <= (w_state_nxt == S_HOLD);
            r_busy     <= (w_state_nxt != S_IDLE);
            // An accepted violation takes priority over a coincident clear.
            if (w_accept) begin
                r_viol_sticky <= 1'b1;
                r_viol_pc     <= pc;
                r_viol_daddr  <= data_addr;
                r_viol_caddr  <= code_addr;
                if (clr_status) begin
                    r_viol_count <= CNT_W'(1);
                end else if (r_viol_count != CNT_MAX) begin
                    r_viol_count <= r_viol_count + CNT_W'(1);
                end
            end else if (clr_status) begin
                r_viol_sticky <= 1'b0;
                r_viol_pc     <= '0;
                r_viol_daddr  <= '0;
                r_viol_caddr  <= '0;
                r_viol_count  <= '0;
            end
        end
    end

    assign cpu_rst     = r_cpu_rst;
    assign busy        = r_busy;
    assign viol_sticky = r_viol_sticky;
    assign viol_pc     = r_viol_pc;
    assign viol_daddr  = r_viol_daddr;
    assign viol_caddr  = r_viol_caddr;
    assign viol_count  = r_viol_count;

endmodule

// File: tb/tb_viol_rst_ctrl.sv
// Bench for viol_rst_ctrl: three parameterisations share one stimulus stream and
// are each compared every cycle against a timeline-based reference model.
module tb_viol_rst_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        violation;
    logic [15:0] pc, data_addr, code_addr;
    logic        clr_status;

    logic        o_rst[3], o_busy[3], o_sticky[3];
    logic [15:0] o_pc[3], o_da[3], o_ca[3];
    logic [7:0]  cnt_a;
    logic [1:0]  cnt_b;
    logic [2:0]  cnt_c;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n   = 0;

    // Reference model state per instance, expressed as edge timestamps.
    int m_hold[3];
    int m_max[3];
    int m_t_acc[3];
    int m_next_ok[3];
    int m_count[3];
    int m_sticky[3];
    int m_pc[3], m_da[3], m_ca[3];

    always #5 clk = ~clk;

    viol_rst_ctrl #(.HOLD_CYCLES(16), .CNT_W(8)) u_a (
        .clk(clk), .reset_n(reset_n), .violation(violation), .pc(pc),
        .data_addr(data_addr), .code_addr(code_addr), .clr_status(clr_status),
        .cpu_rst(o_rst[0]), .busy(o_busy[0]), .viol_sticky(o_sticky[0]),
        .viol_pc(o_pc[0]), .viol_daddr(o_da[0]), .viol_caddr(o_ca[0]),
        .viol_count(cnt_a));

    viol_rst_ctrl #(.HOLD_CYCLES(1), .CNT_W(2)) u_b (
        .clk(clk), .reset_n(reset_n), .violation(violation), .pc(pc),
        .data_addr(data_addr), .code_addr(code_addr), .clr_status(clr_status),
        .cpu_rst(o_rst[1]), .busy(o_busy[1]), .viol_sticky(o_sticky[1]),
        .viol_pc(o_pc[1]), .viol_daddr(o_da[1]), .viol_caddr(o_ca[1]),
        .viol_count(cnt_b));

    viol_rst_ctrl #(.HOLD_CYCLES(5), .CNT_W(3)) u_c (
        .clk(clk), .reset_n(reset_n), .violation(violation), .pc(pc),
        .data_addr(data_addr), .code_addr(code_addr), .clr_status(clr_status),
        .cpu_rst(o_rst[2]), .busy(o_busy[2]), .viol_sticky(o_sticky[2]),
        .viol_pc(o_pc[2]), .viol_daddr(o_da[2]), .viol_caddr(o_ca[2]),
        .viol_count(cnt_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, obs, exp_v);
        end
    endtask

    // Apply the rules for one rising edge using the inputs currently driven.
    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            if (!reset_n) begin
                m_t_acc[i]   = -1000;
                m_next_ok[i] = edge_n + 1;
                m_count[i]   = 0;
                m_sticky[i]  = 0;
                m_pc[i] = 0; m_da[i] = 0; m_ca[i] = 0;
            end else if (violation && edge_n >= m_next_ok[i]) begin
                m_t_acc[i]   = edge_n;
                m_next_ok[i] = edge_n + m_hold[i] + 2;
                m_count[i]   = clr_status ? 1 : ((m_count[i] < m_max[i]) ? m_count[i] + 1 : m_max[i]);
                m_sticky[i]  = 1;
                m_pc[i] = int'(pc); m_da[i] = int'(data_addr); m_ca[i] = int'(code_addr);
            end else if (clr_status) begin
                m_count[i]  = 0;
                m_sticky[i] = 0;
                m_pc[i] = 0; m_da[i] = 0; m_ca[i] = 0;
            end
        end
    endtask

    task automatic check_all();
        logic [31:0] cnt_obs;
        logic        e_rst, e_busy;
        for (int i = 0; i < 3; i++) begin
            cnt_obs = (i == 0) ? 32'(cnt_a) : (i == 1) ? 32'(cnt_b) : 32'(cnt_c);
            // Output after edge e shows cycle e+1: cpu_rst for t..t+H-1, busy one longer.
            e_rst  = (edge_n >= m_t_acc[i]) && (edge_n <= m_t_acc[i] + m_hold[i] - 1);
            e_busy = (edge_n >= m_t_acc[i]) && (edge_n <= m_t_acc[i] + m_hold[i]);
            chk($sformatf("u%0d.cpu_rst", i), 32'(o_rst[i]), 32'(e_rst));
            chk($sformatf("u%0d.busy", i), 32'(o_busy[i]), 32'(e_busy));
            chk($sformatf("u%0d.sticky", i), 32'(o_sticky[i]), 32'(m_sticky[i]));
            chk($sformatf("u%0d.count", i), cnt_obs, 32'(m_count[i]));
            chk($sformatf("u%0d.viol_pc", i), 32'(o_pc[i]), 32'(m_pc[i]));
            chk($sformatf("u%0d.viol_daddr", i), 32'(o_da[i]), 32'(m_da[i]));
            chk($sformatf("u%0d.viol_caddr", i), 32'(o_ca[i]), 32'(m_ca[i]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        edge_n++;
        model_edge();
        #1;
        check_all();
        pc        = 16'($urandom);
        data_addr = 16'($urandom);
        code_addr = 16'($urandom);
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        m_hold = '{16, 1, 5};
        m_max  = '{255, 3, 7};
        for (int i = 0; i < 3; i++) begin
            m_t_acc[i] = -1000; m_next_ok[i] = 0; m_count[i] = 0; m_sticky[i] = 0;
            m_pc[i] = 0; m_da[i] = 0; m_ca[i] = 0;
        end
        reset_n = 1'b0; violation = 1'b0; clr_status = 1'b0;
        pc = '0; data_addr = '0; code_addr = '0;

        steps(2);
        reset_n = 1'b1;
        steps(5);

        // Single pulse with known addresses.
        violation = 1'b1;
        pc = 16'hA010; data_addr = 16'h0600; code_addr = 16'hA010;
        step();
        violation = 1'b0;
        steps(3);
        clr_status = 1'b1;   // clear while instances are in HOLD
        step();
        clr_status = 1'b0;
        steps(30);

        // Continuous request for 40 cycles.
        violation = 1'b1;
        steps(40);
        violation = 1'b0;
        steps(25);

        // Clear coincident with an IDLE acceptance.
        violation = 1'b1; clr_status = 1'b1;
        step();
        violation = 1'b0; clr_status = 1'b0;
        steps(25);

        // Reset during HOLD, then immediate re-acceptance.
        violation = 1'b1;
        step();
        violation = 1'b0;
        steps(4);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1; violation = 1'b1;
        step();
        violation = 1'b0;
        steps(20);

        // Spaced violations to drive the counters into saturation.
        for (int k = 0; k < 10; k++) begin
            violation = 1'b1;
            step();
            violation = 1'b0;
            steps(19);
        end

        // Randomised phases mixing bursts, sparse pulses, clears and resets.
        for (int k = 0; k < 3000; k++) begin
            if ((k % 200) < 60)
                violation = ($urandom_range(0, 3) != 0);
            else
                violation = ($urandom_range(0, 15) == 0);
            clr_status = ($urandom_range(0, 19) == 0);
            reset_n    = ($urandom_range(0, 149) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
